// File: rtl/but_stage_ctrl.sv
// Radix-2 butterfly stage sequencer: buffers an N-sample frame, drives the external adder
// for HALF pairs, then streams sums and differences out. Optional: BUT_STAGE_CTRL_FRAME_CNT_EN.
module but_stage_ctrl #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned N     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  output logic [IN_W-1:0]  but_a,
  output logic [IN_W-1:0]  but_b,
  input  logic [OUT_W-1:0] but_p,
  input  logic [OUT_W-1:0] but_n,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_last,
  output logic             busy
`ifdef BUT_STAGE_CTRL_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int unsigned HALF = N / 2;
  localparam int unsigned AW   = $clog2(N);

  localparam logic [AW-1:0] LastIdx  = AW'(N - 1);
  localparam logic [AW-1:0] HalfIdx  = AW'(HALF);
  localparam logic [AW-1:0] HalfLast = AW'(HALF - 1);

  typedef enum logic [1:0] {StLoad, StCompute, StDrain} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic [AW-1:0] k_hi;

  logic [IN_W-1:0]  in_buf [N];
  logic [OUT_W-1:0] res    [N];

  assign k_hi = k_q + HalfIdx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StLoad;
      wr_idx_q <= '0;
      k_q      <= '0;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      k_q      <= k_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  // Buffers carry no reset; every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (state_q == StLoad && s_valid) begin
      in_buf[wr_idx_q] <= s_data;
    end
    if (state_q == StCompute) begin
      res[k_q]  <= but_p;
      res[k_hi] <= but_n;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    k_d      = k_q;
    rd_idx_d = rd_idx_q;
    s_ready  = 1'b0;
    busy     = 1'b0;
    m_valid  = 1'b0;
    m_data   = '0;
    m_last   = 1'b0;
    but_a    = '0;
    but_b    = '0;
    unique case (state_q)
      StLoad: begin
        s_ready = rst_n;
        if (s_valid) begin
          if (wr_idx_q == LastIdx) begin
            wr_idx_d = '0;
            state_d  = StCompute;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      StCompute: begin
        busy  = 1'b1;
        but_a = in_buf[k_q];
        but_b = in_buf[k_hi];
        if (k_q == HalfLast) begin
          k_d     = '0;
          state_d = StDrain;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDrain: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        m_data  = res[rd_idx_q];
        m_last  = (rd_idx_q == LastIdx);
        if (m_ready) begin
          if (rd_idx_q == LastIdx) begin
            rd_idx_d = '0;
            state_d  = StLoad;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

`ifdef BUT_STAGE_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (state_q == StDrain && m_ready && rd_idx_q == LastIdx) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_but_stage_ctrl.sv
// Scoreboard bench for but_stage_ctrl; models the external butterfly adder.
// Covers the frame counter when BUT_STAGE_CTRL_FRAME_CNT_EN is defined.
module tb_but_stage_ctrl;

  localparam int IN_W  = 8;
  localparam int OUT_W = 8;
  localparam int N     = 32;
  localparam int HALF  = N / 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [IN_W-1:0]  s_data = '0;
  logic [IN_W-1:0]  but_a, but_b;
  logic [OUT_W-1:0] but_p, but_n;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic [OUT_W-1:0] m_data;
  logic             m_last;
  logic             busy;
`ifdef BUT_STAGE_CTRL_FRAME_CNT_EN
  logic [15:0]      frame_cnt;
`endif

  but_stage_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .but_a   (but_a),
    .but_b   (but_b),
    .but_p   (but_p),
    .but_n   (but_n),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .busy    (busy)
`ifdef BUT_STAGE_CTRL_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  // External real butterfly adder: wraps at OUT_W bits.
  assign but_p = OUT_W'($signed(but_a) + $signed(but_b));
  assign but_n = OUT_W'($signed(but_a) - $signed(but_b));

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [OUT_W-1:0] exp_q[$];
  int               out_cnt = 0;
  logic             toggle_ready = 1'b0;
  logic signed [IN_W-1:0] frame [N];

  // Monitor: every valid cycle must show the scoreboard head, stalled or not.
  always @(negedge clk) begin
    if (rst_n && m_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out", 32'(m_data), 32'hdead);
      end else begin
        check_eq("m_data", 32'(m_data), 32'(exp_q[0]));
        check_eq("m_last", 32'(m_last), 32'(out_cnt == N - 1));
        check_eq("s_ready_drain", 32'(s_ready), 0);
        check_eq("busy_drain", 32'(busy), 1);
        if (m_ready) begin
          void'(exp_q.pop_front());
          out_cnt = (out_cnt == N - 1) ? 0 : out_cnt + 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    m_ready = toggle_ready ? ~m_ready : 1'b1;
  end

  task automatic send_frame(input int gap);
    for (int k = 0; k < HALF; k++) begin
      int a = frame[k];
      int b = frame[k + HALF];
      exp_q.push_back(OUT_W'(a + b));
    end
    for (int k = 0; k < HALF; k++) begin
      int a = frame[k];
      int b = frame[k + HALF];
      exp_q.push_back(OUT_W'(a - b));
    end
    for (int i = 0; i < N; i++) begin
      s_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check_eq("s_ready_gap", 32'(s_ready), 1);
        @(posedge clk);
        #1;
      end
      s_valid = 1'b1;
      s_data  = frame[i];
      @(negedge clk);
      check_eq("s_ready_load", 32'(s_ready), 1);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_eq("drain_done", 32'(exp_q.size()), 0);
    @(negedge clk);
    check_eq("s_ready_after", 32'(s_ready), 1);
    check_eq("m_valid_after", 32'(m_valid), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_m_valid"}, 32'(m_valid), 0);
    check_eq({tag, "_m_last"}, 32'(m_last), 0);
    check_eq({tag, "_m_data"}, 32'(m_data), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_s_ready"}, 32'(s_ready), 0);
    check_eq({tag, "_but_a"}, 32'(but_a), 0);
    check_eq({tag, "_but_b"}, 32'(but_b), 0);
  endtask

  task automatic ramp();
    for (int i = 0; i < N; i++) frame[i] = IN_W'(i);
  endtask

  initial begin
    int lat;
    #2;
    check_idle("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("s_ready_idle", 32'(s_ready), 1);
    check_eq("but_a_load", 32'(but_a), 0);
    @(posedge clk);
    #1;

    // Ramp frame; latency counts the final handshake edge itself.
    ramp();
    send_frame(0);
    lat = 1;
    while (!m_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("latency", 32'(lat), HALF + 1);
    wait_drain();

    // Input gaps: valid every third cycle, constant samples.
    for (int i = 0; i < N; i++) frame[i] = IN_W'(5);
    send_frame(2);
    wait_drain();

    // Backpressure on the output.
    ramp();
    toggle_ready = 1'b1;
    send_frame(0);
    wait_drain();
    toggle_ready = 1'b0;

    // Reset in the middle of COMPUTE at k = 7.
    ramp();
    send_frame(0);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    check_eq("busy_compute", 32'(busy), 1);
    check_eq("but_a_k7", 32'(but_a), 7);
    check_eq("but_b_k7", 32'(but_b), 7 + HALF);
    rst_n = 1'b0;
    #1;
    check_idle("midreset");
    exp_q.delete();
    out_cnt = 0;
    @(posedge clk);
    #1;
    check_idle("midreset_hold");
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) frame[i] = IN_W'(100);
    send_frame(0);
    wait_drain();

    // Back-to-back ramp frames.
    ramp();
    send_frame(0);
    wait_drain();
    send_frame(0);
    wait_drain();

`ifdef BUT_STAGE_CTRL_FRAME_CNT_EN
    rst_n = 1'b0;
    #1;
    check_eq("frame_cnt_reset", 32'(frame_cnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int f = 0; f < 3; f++) begin
      send_frame(0);
      wait_drain();
      check_eq("frame_cnt", 32'(frame_cnt), f + 1);
    end
    force dut.frame_cnt_q = 16'hffff;
    @(posedge clk);
    #1;
    release dut.frame_cnt_q;
    send_frame(0);
    wait_drain();
    check_eq("frame_cnt_wrap", 32'(frame_cnt), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
